// File: rtl/gb_bank_fifo.sv
// gb_bank_fifo: runs one single-port SRAM macro as a streaming FIFO between
// a DMA write stream and a PE-array read stream. Each cycle the SRAM port is
// given to at most one write or one read. A 2-entry output stage absorbs the
// macro's 1-cycle read latency so a continuously ready consumer is never starved.
//
// Handshakes: a write word transfers in any cycle where wr_vld & wr_rdy are both
// high (wr_rdy is a combinational function of wr_vld and is low during clear and
// reset); a read word transfers in any cycle where rd_vld & rd_rdy are both high
// (rd_vld is registered state, and rd_dat holds while rd_vld=1 and rd_rdy=0).
module gb_bank_fifo #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    output logic                  rd_vld,
    input  logic                  rd_rdy,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_di,
    output logic                  sram_csb,
    output logic                  sram_web,
    input  logic [DATA_WIDTH-1:0] sram_do
);

    // mem_cnt value meaning "every SRAM entry holds a word"
    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_cnt;
    logic                  r_inflight;
    logic                  r_last_gnt;   // 1: read won the last contention
    logic [DATA_WIDTH-1:0] r_out_mem [2];
    logic                  r_out_rp;
    logic                  r_out_wp;
    logic [1:0]            r_out_cnt;

    logic                  w_rd_vld;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_credit;
    logic                  w_want_wr;
    logic                  w_want_rd;
    logic                  w_gnt_wr;
    logic                  w_gnt_rd;

    assign w_rd_vld = (r_out_cnt != 2'd0);
    assign w_pop    = w_rd_vld & rd_rdy;
    // Data returned by last cycle's read lands in the output stage unless flushed.
    assign w_push   = r_inflight & ~clear;
    // Output-stage slots already spoken for, crediting this cycle's pop so a
    // steady consumer keeps a read issued every cycle.
    assign w_credit = 3'(r_out_cnt) + 3'(r_inflight) - 3'(w_pop);

    assign w_want_wr = rst_n & wr_vld & (r_mem_cnt != DEPTH_V) & ~clear;
    assign w_want_rd = rst_n & (r_mem_cnt != '0) & (w_credit < 3'd2) & ~clear;

    // On contention the side that lost the previous contention wins.
    assign w_gnt_wr = w_want_wr & (~w_want_rd | r_last_gnt);
    assign w_gnt_rd = w_want_rd & (~w_want_wr | ~r_last_gnt);

    // Drive the SRAM port for the granted operation; park it at zero when idle.
    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_di  = '0;
        if (w_gnt_wr) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = r_wr_ptr;
            sram_di  = wr_dat;
        end else if (w_gnt_rd) begin
            sram_csb = 1'b0;
            sram_a   = r_rd_ptr;
        end
    end

    // SRAM-side bookkeeping: pointers, occupancy, read in flight, tie-break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_last_gnt <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_last_gnt <= 1'b0;
        end else begin
            r_inflight <= w_gnt_rd;
            if (w_want_wr && w_want_rd) begin
                r_last_gnt <= w_gnt_rd;
            end
            if (w_gnt_wr) begin
                r_wr_ptr  <= r_wr_ptr + ADDR_WIDTH'(1);
                r_mem_cnt <= r_mem_cnt + (ADDR_WIDTH+1)'(1);
            end else if (w_gnt_rd) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
                r_mem_cnt <= r_mem_cnt - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Two-entry output stage fed by SRAM read data and drained by the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_mem[0] <= '0;
            r_out_mem[1] <= '0;
            r_out_rp     <= 1'b0;
            r_out_wp     <= 1'b0;
            r_out_cnt    <= 2'd0;
        end else if (clear) begin
            r_out_rp  <= 1'b0;
            r_out_wp  <= 1'b0;
            r_out_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_out_mem[r_out_wp] <= sram_do;
                r_out_wp            <= ~r_out_wp;
            end
            if (w_pop) begin
                r_out_rp <= ~r_out_rp;
            end
            r_out_cnt <= r_out_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    assign wr_rdy = w_gnt_wr;
    assign rd_vld = w_rd_vld;
    assign rd_dat = w_rd_vld ? r_out_mem[r_out_rp] : '0;
    assign count  = (ADDR_WIDTH+2)'(r_mem_cnt) + (ADDR_WIDTH+2)'(r_inflight)
                  + (ADDR_WIDTH+2)'(r_out_cnt);
    assign full   = (r_mem_cnt == DEPTH_V);
    assign empty  = (count == '0);

endmodule

// File: tb/tb_gb_bank_fifo.sv
// Testbench for gb_bank_fifo: behavioural SRAM, stimulus driver, and a
// scoreboard that holds every accepted word in arrival order.
module tb_gb_bank_fifo;

    localparam int AW    = 9;
    localparam int DW    = 128;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          wr_vld;
    logic          wr_rdy;
    logic [DW-1:0] wr_dat;
    logic          rd_vld;
    logic          rd_rdy;
    logic [DW-1:0] rd_dat;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_di;
    logic          sram_csb;
    logic          sram_web;
    logic [DW-1:0] sram_do;

    logic [DW-1:0] exp_q[$];
    int            n_cmp;
    int            n_err;
    logic          prev_hold;
    logic [DW-1:0] prev_dat;

    gb_bank_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_vld   (wr_vld),
        .wr_rdy   (wr_rdy),
        .wr_dat   (wr_dat),
        .rd_vld   (rd_vld),
        .rd_rdy   (rd_rdy),
        .rd_dat   (rd_dat),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .sram_a   (sram_a),
        .sram_di  (sram_di),
        .sram_csb (sram_csb),
        .sram_web (sram_web),
        .sram_do  (sram_do)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural SRAM macro ----------------
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) sram_mem[sram_a] <= sram_di;
            else           sram_do <= sram_mem[sram_a];
        end
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Sampled mid-cycle: inputs are stable and all state reflects the last edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else if (clear) begin
            check("clear_wr_rdy", wr_rdy, 0);
            check("clear_csb", sram_csb, 1);
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check("count", count, exp_q.size());
            check("empty", empty, (exp_q.size() == 0));
            if (exp_q.size() < DEPTH)     check("full_low", full, 0);
            if (exp_q.size() >= DEPTH + 2) begin
                check("full_high", full, 1);
                check("wr_rdy_cap", wr_rdy, 0);
            end
            if (sram_csb) begin
                check("idle_web", sram_web, 1);
                check("idle_a", sram_a, 0);
                check("idle_di", sram_di, 0);
            end
            if (prev_hold) begin
                check("hold_vld", rd_vld, 1);
                check("hold_dat", rd_dat, prev_dat);
            end
            if (rd_vld && rd_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_extra: got word %0h required none", rd_dat);
                end else begin
                    check("rd_dat", rd_dat, exp_q.pop_front());
                end
            end
            if (wr_vld && wr_rdy) exp_q.push_back(wr_dat);
            prev_hold = rd_vld && !rd_rdy;
            prev_dat  = rd_dat;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        bit ok;
        ok     = 1'b0;
        wr_vld = 1'b1;
        wr_dat = d;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (wr_rdy) ok = 1'b1;
            step();
            if (ok) break;
        end
        wr_vld = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_timeout: word %0h got no wr_rdy, required accept", d);
        end
    endtask

    task automatic wait_empty(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: count=%0d after %0d cycles, required 0", name, count, bound);
        end
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        logic        acc;
        logic        prev_web;
        logic [DW-1:0] d;

        n_cmp = 0; n_err = 0; prev_hold = 1'b0; prev_dat = '0;
        rst_n = 1'b0; clear = 1'b0; wr_vld = 1'b0; rd_rdy = 1'b0; wr_dat = '0;

        // reset values
        #2;
        check("rst_wr_rdy", wr_rdy, 0);
        check("rst_rd_vld", rd_vld, 0);
        check("rst_rd_dat", rd_dat, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_csb", sram_csb, 1);
        check("rst_web", sram_web, 1);
        check("rst_a", sram_a, 0);
        check("rst_di", sram_di, 0);
        #20 rst_n = 1'b1;
        step();

        // write-to-read latency on an idle bank
        wr_vld = 1'b1; wr_dat = 'h11;
        @(negedge clk);
        check("lat_accept", wr_rdy, 1);
        step();
        wr_vld = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rd_vld) begin
                lat = k;
                break;
            end
        end
        check("lat_cycles", lat, 3);
        step();
        rd_rdy = 1'b1;
        wait_empty(50, "lat_drain");
        rd_rdy = 1'b0;

        // four words held back, then drained in order
        for (int i = 0; i < 4; i++) write_word(DW'('hA0 + i));
        repeat (4) step();
        @(negedge clk);
        check("four_count", count, 4);
        check("four_head", rd_dat, 'hA0);
        step();
        rd_rdy = 1'b1;
        wait_empty(50, "four_drain");
        rd_rdy = 1'b0;

        // fill past DEPTH with the consumer stalled, then drain across the wrap
        for (int i = 0; i < DEPTH + 2; i++) write_word(DW'('h1000 + i));
        repeat (4) step();
        @(negedge clk);
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH + 2);
        step();
        wr_vld = 1'b1; wr_dat = 'hDEAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fill_wr_rdy", wr_rdy, 0);
            step();
        end
        wr_vld = 1'b0;
        rd_rdy = 1'b1;
        wait_empty(3000, "fill_drain");
        rd_rdy = 1'b0;

        // simultaneous streams: grants alternate once the bank is primed
        wr_vld = 1'b1; rd_rdy = 1'b1; wr_dat = 'h2000;
        prev_web = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c >= 12) begin
                check("alt_csb", sram_csb, 0);
                check("alt_web", sram_web, !prev_web);
            end
            acc      = wr_rdy;
            prev_web = sram_web;
            step();
            if (acc) wr_dat = wr_dat + 1'b1;
        end
        wr_vld = 1'b0;
        wait_empty(50, "alt_drain");
        rd_rdy = 1'b0;

        // random traffic with a 50% consumer
        for (int c = 0; c < 3000; c++) begin
            wr_vld = 1'($urandom_range(0, 1));
            wr_dat = {$urandom, $urandom, $urandom, $urandom};
            rd_rdy = 1'($urandom_range(0, 1));
            step();
        end
        wr_vld = 1'b0; rd_rdy = 1'b1;
        wait_empty(3000, "rand_drain");
        rd_rdy = 1'b0;

        // clear while a read is in flight
        write_word('h77);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        check("clr_count", count, 0);
        check("clr_rd_vld", rd_vld, 0);
        step();
        write_word('h55);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd_vld) break;
        end
        check("clr_vld_55", rd_vld, 1);
        check("clr_dat_55", rd_dat, 'h55);
        step();
        rd_rdy = 1'b1;
        wait_empty(50, "clr_drain");

        // asynchronous reset in the middle of a stream
        wr_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            wr_dat = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_csb", sram_csb, 1);
        check("arst_rd_vld", rd_vld, 0);
        check("arst_wr_rdy", wr_rdy, 0);
        check("arst_empty", empty, 1);
        check("arst_count", count, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wr_vld = 1'b0; rd_rdy = 1'b0;
        step();
        write_word('h99);
        rd_rdy = 1'b1;
        wait_empty(50, "arst_drain");
        rd_rdy = 1'b0;

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
